// File: rtl/lc3b_mem_arbiter.sv
// Two-port (fetch A, data B) to single memory port arbiter with conflict counter.
// Define LC3B_ARB_ROUND_ROBIN_EN for round-robin grants on conflict.
module lc3b_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                read_a,
  input  logic [ADDR_W-1:0]   address_a,
  output logic                resp_a,
  output logic [DATA_W-1:0]   rdata_a,
  input  logic                read_b,
  input  logic                write_b,
  input  logic [ADDR_W-1:0]   address_b,
  input  logic [DATA_W-1:0]   wdata_b,
  input  logic [DATA_W/8-1:0] wmask_b,
  output logic                resp_b,
  output logic [DATA_W-1:0]   rdata_b,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                conflict_count_reset,
  output logic [CNT_W-1:0]    conflict_count
);

  localparam int MW = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_A,
    SERVE_B
  } state_e;

  state_e              state_q, state_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MW-1:0]       wmask_q, wmask_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                req_a, req_b;
  logic                conflict, grant_b;
`ifdef LC3B_ARB_ROUND_ROBIN_EN
  logic                last_b_q, last_b_d;
`endif

  always_comb begin
    req_a    = read_a;
    req_b    = read_b | write_b;
    conflict = req_a & req_b;
`ifdef LC3B_ARB_ROUND_ROBIN_EN
    grant_b  = req_b & (~req_a | ~last_b_q);
    last_b_d = last_b_q;
`else
    grant_b  = req_b;
`endif
    state_d  = state_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (grant_b) begin
          state_d  = SERVE_B;
          // simultaneous read+write collapses to a write
          rd_d     = read_b & ~write_b;
          wr_d     = write_b;
          addr_d   = address_b;
          wdata_d  = wdata_b;
          wmask_d  = wmask_b;
`ifdef LC3B_ARB_ROUND_ROBIN_EN
          last_b_d = 1'b1;
`endif
        end else if (req_a) begin
          state_d  = SERVE_A;
          rd_d     = 1'b1;
          wr_d     = 1'b0;
          addr_d   = address_a;
          wdata_d  = '0;
          wmask_d  = '1;
`ifdef LC3B_ARB_ROUND_ROBIN_EN
          last_b_d = 1'b0;
`endif
        end
        if (conflict && cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SERVE_A, SERVE_B: begin
        if (mem_resp) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (conflict_count_reset) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      cnt_q    <= '0;
`ifdef LC3B_ARB_ROUND_ROBIN_EN
      last_b_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      cnt_q    <= cnt_d;
`ifdef LC3B_ARB_ROUND_ROBIN_EN
      last_b_q <= last_b_d;
`endif
    end
  end

  // response routing is combinational so resp lands in the mem_resp cycle
  assign resp_a         = (state_q == SERVE_A) & mem_resp;
  assign resp_b         = (state_q == SERVE_B) & mem_resp;
  assign rdata_a        = resp_a ? mem_rdata : '0;
  assign rdata_b        = resp_b ? mem_rdata : '0;
  assign mem_read       = rd_q;
  assign mem_write      = wr_q;
  assign mem_address    = addr_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;
  assign conflict_count = cnt_q;

endmodule

// File: doc/lc3b_mem_arbiter.md
Name: lc3b_mem_arbiter

Overview:
- Shares one physical memory port between the pipeline's instruction-fetch port (A, read-only) and data port (B, read/write).
- Sits between the CPU datapath's two memory ports and the single memory/L2 interface.
- Serializes requests through a small FSM and routes each response back to the requester that owns it.
- Counts arbitration conflicts for performance monitoring.

Parameters:
- ADDR_W, 16, address width of all ports.
- DATA_W, 16, data width of all ports (wmask width = DATA_W/8).
- CNT_W, 16, width of the conflict counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- read_a  in  1  port A read request; held until resp_a.
- address_a  in  ADDR_W  port A address; stable while read_a is high.
- resp_a  out  1  port A completion pulse.
- rdata_a  out  DATA_W  port A read data; valid when resp_a=1.
- read_b / write_b  in  1  port B request; held until resp_b.
- address_b  in  ADDR_W  port B address.
- wdata_b  in  DATA_W  port B write data.
- wmask_b  in  DATA_W/8  port B byte mask.
- resp_b  out  1  port B completion pulse.
- rdata_b  out  DATA_W  port B read data; valid when resp_b=1.
- mem_read / mem_write  out  1  downstream request.
- mem_address  out  ADDR_W  downstream address.
- mem_wdata  out  DATA_W  downstream write data.
- mem_wmask  out  DATA_W/8  downstream byte mask.
- mem_resp  in  1  downstream completion.
- mem_rdata  in  DATA_W  downstream read data.
- conflict_count_reset  in  1  synchronous clear of conflict_count.
- conflict_count  out  CNT_W  number of IDLE cycles with both ports requesting.

Behaviour:
- States: IDLE, SERVE_A, SERVE_B.
- Reset (async, on reset_n=0):
  - State goes to IDLE.
  - All downstream request registers, address, wdata and wmask clear to 0.
  - conflict_count clears to 0; the round-robin pointer (if compiled in) clears to "last=A".
  - resp_a=resp_b=0.
  - An in-flight transaction is abandoned; the downstream memory must tolerate its request dropping.
- IDLE:
  - Sample requests; req_b = read_b | write_b.
  - Neither port requesting: stay in IDLE.
  - Only A requesting: go to SERVE_A.
  - Only B requesting: go to SERVE_B.
  - Both requesting: go to SERVE_B (fixed priority, B wins); conflict_count increments.
  - On the grant edge, capture the granted port's request bits, address, wdata and wmask into output registers. For port A: wdata=0, wmask=all-ones, write=0.
  - If read_b and write_b are both high, the captured request is a write only.
- SERVE_x:
  - Drive the registered request downstream, held stable until mem_resp.
  - Requester inputs are not re-sampled during SERVE_x.
  - On a cycle with mem_resp=1: resp_x=1 and rdata_x=mem_rdata, combinationally in that same cycle. Clear the downstream request registers; next state is IDLE.
- The non-owner resp output is 0 at all times; rdata of the non-owner is don't-care (drive 0).
- The forced IDLE cycle after each response is mandatory:
  - It gives the memory one deasserted cycle between transactions.
  - It lets the requester update its address before re-arbitration.
- Latency: request visible in IDLE cycle c → mem_read/mem_write high from cycle c+1 → resp_x in the cycle mem_resp arrives. Minimum 2 cycles from request to resp with a zero-wait memory.
- A mem_resp seen in IDLE is ignored and produces no resp pulse.
- conflict_count:
  - Saturates at all-ones.
  - conflict_count_reset has priority over an increment in the same cycle.
- A request deasserted before its resp is a protocol violation; the transaction still completes and resp is still pulsed.

Optional Feature:
- Macro: LC3B_ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last-served pointer updates on every grant.
  - On conflict, the grant goes to the port not last served. Conflict counting is unchanged.
- Undefined:
  - Fixed priority, B over A; no pointer register exists.

Test Plan:
- Single A read: read_a=1, address_a=0x0100, memory returns 0x1234 after 3 wait cycles → mem_read high from the cycle after request with mem_address=0x0100, resp_a=1 with rdata_a=0x1234 in the mem_resp cycle, then one IDLE cycle with mem_read=0.
- B write: write_b=1, address_b=0x2000, wdata_b=0xBEEF, wmask_b=2'b01 → mem_write=1, mem_wdata=0xBEEF, mem_wmask=2'b01 held until mem_resp; resp_b pulses one cycle; resp_a stays 0.
- Conflict: read_a and read_b asserted together for three back-to-back requests → without the macro, B served first, A only after B's queue empties; conflict_count increments once per conflicting IDLE cycle. With the macro, grants alternate B, A, B.
- Counter: force 0xFFFF conflicts → conflict_count holds 0xFFFF. Assert conflict_count_reset together with a conflict → conflict_count=0.
- Reset mid-transaction: reset_n=0 while in SERVE_B with mem_write=1 → mem_write, resp_b and conflict_count are 0 immediately (asynchronously); FSM in IDLE after release; a later mem_resp gives no resp pulse.
- Both read_b and write_b high with address 0x3000 → a single downstream write is issued, mem_read=0.
